fetch_sequencer: RTL and testbench

- Control block that drives `pc_prima` of the CPU program counter, which has no enable.
- Sequences instruction fetch with the instruction memory through a req/ready handshake.
- Holds the PC on stalls and memory wait, and applies branch redirects, including those arriving mid-fetch.
- Handles halt and, optionally, interrupt entry.
- Sits between the control unit/branch logic and the program counter.

---
 rtl/fetch_sequencer_pkg.sv | 18 +
 rtl/fetch_sequencer_if.sv | 40 ++++
 rtl/fetch_sequencer_redirect_buf.sv | 43 ++++
 rtl/fetch_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer slice.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_IRQ_VECTOR   = 32'h0000_0018;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between control/branch logic, the program counter and instruction memory.
// Interrupt signals exist only when FETCH_SEQUENCER_IRQ_EN is defined.
interface fetch_sequencer_if;

    logic [31:0] pc;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt;
    logic        imem_ready;
    logic [31:0] pc_prima;
    logic        imem_req;
    logic        fetch_valid;
    logic        halted;
`ifdef FETCH_SEQUENCER_IRQ_EN
    logic        irq;
    logic        irq_ret;
    logic        irq_ack;
    logic [31:0] epc;
`endif

    modport master (
        input  pc, stall, branch_taken, branch_target, halt, imem_ready,
`ifdef FETCH_SEQUENCER_IRQ_EN
        input  irq, irq_ret,
        output irq_ack, epc,
`endif
        output pc_prima, imem_req, fetch_valid, halted
    );

    modport slave (
        output pc, stall, branch_taken, branch_target, halt, imem_ready,
`ifdef FETCH_SEQUENCER_IRQ_EN
        output irq, irq_ret,
        input  irq_ack, epc,
`endif
        input  pc_prima, imem_req, fetch_valid, halted
    );

endinterface

// File: rtl/fetch_sequencer_redirect_buf.sv
// Pending branch redirect: captures a word-aligned target, newer captures overwrite,
// and a clear drops it once the redirect has been applied.
module fetch_redirect_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_i,
    input  logic [31:0] target_i,
    input  logic        clear_i,
    output logic        valid_o,
    output logic [31:0] target_o
);

    logic        valid_q, valid_d;
    logic [31:0] target_q, target_d;

    // Capture wins over clear; the two are never requested together by the sequencer.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (capture_i) begin
            valid_d  = 1'b1;
            target_d = align_word(target_i);
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Drives pc_prima of an enable-less program counter and sequences instruction fetch.
// Define FETCH_SEQUENCER_IRQ_EN to add interrupt entry/return.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
`ifdef FETCH_SEQUENCER_IRQ_EN
    , parameter logic [31:0] IRQ_VECTOR = DEFAULT_IRQ_VECTOR
`endif
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  fetch_if
);

    fetch_state_e state_q, state_d;
    logic         fetch_done;
    logic         pend_valid;
    logic [31:0]  pend_target;

    assign fetch_done = (state_q == FETCH) && fetch_if.imem_ready && !fetch_if.stall;

    // Redirects seen while the fetch cannot complete are parked until it does.
    fetch_redirect_buf u_redirect (
        .clk       (clk),
        .reset     (reset),
        .capture_i ((state_q == FETCH) && !fetch_done && fetch_if.branch_taken),
        .target_i  (fetch_if.branch_target),
        .clear_i   (fetch_done),
        .valid_o   (pend_valid),
        .target_o  (pend_target)
    );

`ifdef FETCH_SEQUENCER_IRQ_EN
    logic        mask_q;
    logic [31:0] epc_q;
    logic        irq_enter;
    logic        irq_leave;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (fetch_done && fetch_if.halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        fetch_if.pc_prima    = fetch_if.pc;
        fetch_if.imem_req    = 1'b0;
        fetch_if.fetch_valid = 1'b0;
        fetch_if.halted      = 1'b0;
`ifdef FETCH_SEQUENCER_IRQ_EN
        irq_enter            = 1'b0;
        irq_leave            = 1'b0;
`endif
        unique case (state_q)
            BOOT: fetch_if.pc_prima = RESET_VECTOR;
            FETCH: begin
                fetch_if.imem_req = !fetch_if.stall;
                if (fetch_done) begin
                    fetch_if.fetch_valid = 1'b1;
                    if (fetch_if.branch_taken) begin
                        fetch_if.pc_prima = align_word(fetch_if.branch_target);
                    end else if (pend_valid) begin
                        fetch_if.pc_prima = pend_target;
                    end
`ifdef FETCH_SEQUENCER_IRQ_EN
                    else if (fetch_if.irq_ret) begin
                        fetch_if.pc_prima = epc_q;
                        irq_leave         = 1'b1;
                    end else if (fetch_if.irq && !mask_q && !fetch_if.halt) begin
                        fetch_if.pc_prima = IRQ_VECTOR;
                        irq_enter         = 1'b1;
                    end
`endif
                    else begin
                        fetch_if.pc_prima = fetch_if.pc + INSTR_BYTES;
                    end
                end
            end
            HALTED:  fetch_if.halted = 1'b1;
            default: fetch_if.pc_prima = RESET_VECTOR;
        endcase
    end

`ifdef FETCH_SEQUENCER_IRQ_EN
    // Mask blocks nested entry until the handler returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= 1'b0;
            epc_q  <= '0;
        end else if (irq_enter) begin
            mask_q <= 1'b1;
            epc_q  <= fetch_if.pc + INSTR_BYTES;
        end else if (irq_leave) begin
            mask_q <= 1'b0;
        end
    end

    assign fetch_if.irq_ack = irq_enter;
    assign fetch_if.epc     = epc_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: completed fetches are checked by a monitor,
// side conditions (wait, stall, halt, reset) are checked by the stimulus thread.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] pcModel;
    int          total;
    int          bad;
    logic [63:0] expQ[$];

    fetch_sequencer_if bus();

    fetch_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .fetch_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter without enable: loads pc_prima every cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) pcModel <= 32'h0;
        else       pcModel <= bus.pc_prima;
    end
    assign bus.pc = pcModel;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expectFetch(input logic [31:0] pcExp, input logic [31:0] nextExp);
        expQ.push_back({pcExp, nextExp});
    endtask

    task automatic applyStimulus(input logic rdy, input logic stl, input logic br,
                                 input logic [31:0] tgt, input logic hlt);
        @(posedge clk);
        #1;
        bus.imem_ready    = rdy;
        bus.stall         = stl;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.halt          = hlt;
    endtask

    // Monitor: every reported fetch must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.fetch_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_fetch", 32'(bus.pc), 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = expQ.pop_front();
                checkOutput("fetch_pc", bus.pc, e[63:32]);
                checkOutput("fetch_pc_prima", bus.pc_prima, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.imem_ready    = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.halt          = 1'b0;
`ifdef FETCH_SEQUENCER_IRQ_EN
        bus.irq     = 1'b0;
        bus.irq_ret = 1'b0;
`endif
        @(negedge clk);
        checkOutput("reset_pc_prima", bus.pc_prima, 32'h0);
        checkOutput("reset_imem_req", 32'(bus.imem_req), 32'h0);
        checkOutput("reset_fetch_valid", 32'(bus.fetch_valid), 32'h0);
        checkOutput("reset_halted", 32'(bus.halted), 32'h0);

        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("boot_pc_prima", bus.pc_prima, 32'h0);
        checkOutput("boot_imem_req", 32'(bus.imem_req), 32'h0);

        // Straight-line fetch with memory always ready.
        for (int i = 0; i < 4; i++) begin
            expectFetch(32'(i * 4), 32'(i * 4 + 4));
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        end

        // Memory wait at 0x10; a halt during the wait must be ignored.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, (i == 1));
            @(negedge clk);
            checkOutput("wait_pc_prima", bus.pc_prima, 32'h10);
            checkOutput("wait_imem_req", 32'(bus.imem_req), 32'h1);
            checkOutput("wait_fetch_valid", 32'(bus.fetch_valid), 32'h0);
            checkOutput("wait_halted", 32'(bus.halted), 32'h0);
        end
        expectFetch(32'h10, 32'h14);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Branch arriving mid-fetch is parked and applied on completion.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h203, 1'b0);
        @(negedge clk);
        checkOutput("pend_hold_pc_prima", bus.pc_prima, 32'h14);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("pend_hold2_pc_prima", bus.pc_prima, 32'h14);
        expectFetch(32'h14, 32'h200);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Branch coinciding with ready: no bubble.
        expectFetch(32'h200, 32'h40);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h41, 1'b0);

        // Stall beats ready; redirects during stall overwrite one another.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h500, 1'b0);
        @(negedge clk);
        checkOutput("stall_imem_req", 32'(bus.imem_req), 32'h0);
        checkOutput("stall_fetch_valid", 32'(bus.fetch_valid), 32'h0);
        checkOutput("stall_pc_prima", bus.pc_prima, 32'h40);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h603, 1'b0);
        @(negedge clk);
        checkOutput("stall2_pc_prima", bus.pc_prima, 32'h40);
        expectFetch(32'h40, 32'h600);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Wrap at the top of the address space, then halt.
        expectFetch(32'h600, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        expectFetch(32'hFFFF_FFFC, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        expectFetch(32'h0, 32'h4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            checkOutput("halted_flag", 32'(bus.halted), 32'h1);
            checkOutput("halted_imem_req", 32'(bus.imem_req), 32'h0);
            checkOutput("halted_fetch_valid", 32'(bus.fetch_valid), 32'h0);
            checkOutput("halted_pc_prima", bus.pc_prima, 32'h4);
        end

        // Asynchronous reset out of HALTED takes effect without a clock edge.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_pc_prima", bus.pc_prima, 32'h0);
        checkOutput("async_reset_halted", 32'(bus.halted), 32'h0);
        checkOutput("async_reset_imem_req", 32'(bus.imem_req), 32'h0);

`ifdef FETCH_SEQUENCER_IRQ_EN
        @(posedge clk);
        #1 reset = 1'b0;
        expectFetch(32'h0, 32'h100);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
        expectFetch(32'h100, 32'h18);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        bus.irq = 1'b1;
        @(negedge clk);
        checkOutput("irq_ack_entry", 32'(bus.irq_ack), 32'h1);
        expectFetch(32'h18, 32'h1C);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("irq_ack_masked", 32'(bus.irq_ack), 32'h0);
        checkOutput("irq_epc", bus.epc, 32'h104);
        expectFetch(32'h1C, 32'h104);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        bus.irq     = 1'b0;
        bus.irq_ret = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        bus.irq_ret = 1'b0;
`endif

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
